// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulator, per-product stock counters,
// dispenser/hopper valid-ack handshakes and an idle-timeout refund. Values are in Rs10 units.
module vend_ctrl_multi #(
    parameter int unsigned NUM_PROD    = 4,
    parameter int unsigned PRICE_W     = 4,
    parameter int unsigned CREDIT_W    = 6,
    parameter int unsigned MAX_CREDIT  = 10,
    parameter int unsigned STOCK_W     = 4,
    parameter int unsigned STOCK_INIT  = 8,
    parameter int unsigned TIMEOUT_CYC = 1000,
    localparam int unsigned ID_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [1:0]                    cash_i,
    input  logic                          sel_valid_i,
    input  logic [ID_W-1:0]               sel_id_i,
    input  logic                          cancel_i,
    input  logic [NUM_PROD*PRICE_W-1:0]   price_tbl_i,
    input  logic                          restock_i,
    input  logic [ID_W-1:0]               restock_id_i,
    output logic                          dispense_o,
    output logic [ID_W-1:0]               disp_id_o,
    input  logic                          disp_ack_i,
    output logic                          chg_valid_o,
    output logic [CREDIT_W-1:0]           chg_amt_o,
    input  logic                          chg_ready_i,
    output logic                          coin_reject_o,
    output logic                          sel_err_o,
    output logic [NUM_PROD-1:0]           sold_out_o,
    output logic [CREDIT_W-1:0]           credit_o
);

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

    state_e                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [STOCK_W-1:0]    stock_q [NUM_PROD];
    logic [STOCK_W-1:0]    stock_d [NUM_PROD];
    logic                  dispense_q, dispense_d;
    logic [ID_W-1:0]       disp_id_q, disp_id_d;
    logic                  chg_valid_q, chg_valid_d;
    logic [CREDIT_W-1:0]   chg_amt_q, chg_amt_d;
    logic                  coin_reject_q, coin_reject_d;
    logic                  sel_err_q, sel_err_d;
    logic [NUM_PROD-1:0]   sold_out_q, sold_out_d;

    logic                  coin;
    logic [CREDIT_W:0]     coin_val;
    logic [CREDIT_W:0]     credit_sum;
    logic                  coin_fits;
    logic [PRICE_W-1:0]    sel_price;
    logic [CREDIT_W-1:0]   sel_price_ext;
    logic                  sel_ok;

    always_comb begin
        coin_val = '0;
        unique case (cash_i)
            2'b01:   coin_val = (CREDIT_W+1)'(1);
            2'b10:   coin_val = (CREDIT_W+1)'(2);
            2'b11:   coin_val = (CREDIT_W+1)'(5);
            default: coin_val = '0;
        endcase
    end

    // One extra bit on the sum so an over-limit coin can never wrap into range.
    assign coin          = (cash_i != 2'b00);
    assign credit_sum    = {1'b0, credit_q} + coin_val;
    assign coin_fits     = (credit_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign sel_price     = price_tbl_i[sel_id_i*PRICE_W +: PRICE_W];
    assign sel_price_ext = CREDIT_W'(sel_price);
    assign sel_ok        = (stock_q[sel_id_i] != '0) && (credit_q >= sel_price_ext);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        timer_d       = timer_q;
        stock_d       = stock_q;
        dispense_d    = dispense_q;
        disp_id_d     = disp_id_q;
        chg_valid_d   = chg_valid_q;
        chg_amt_d     = chg_amt_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;

        unique case (state_q)
            StIdle, StCredit: begin
                if (restock_i && (state_q == StIdle)) begin
                    stock_d[restock_id_i] = STOCK_W'(STOCK_INIT);
                end
                if (cancel_i && (state_q == StCredit)) begin
                    coin_reject_d = coin;
                    state_d       = StChange;
                    chg_valid_d   = 1'b1;
                    chg_amt_d     = credit_q;
                    timer_d       = '0;
                end else if (sel_valid_i) begin
                    coin_reject_d = coin;
                    if (sel_ok) begin
                        credit_d   = credit_q - sel_price_ext;
                        disp_id_d  = sel_id_i;
                        dispense_d = 1'b1;
                        state_d    = StVend;
                        timer_d    = '0;
                    end else begin
                        sel_err_d = 1'b1;
                        timer_d   = '0;
                    end
                end else if (coin && coin_fits && !cancel_i) begin
                    credit_d = credit_sum[CREDIT_W-1:0];
                    state_d  = StCredit;
                    timer_d  = '0;
                end else begin
                    coin_reject_d = coin;
                    if (state_q == StCredit) begin
                        if (timer_q == TMR_LAST) begin
                            state_d     = StChange;
                            chg_valid_d = 1'b1;
                            chg_amt_d   = credit_q;
                            timer_d     = '0;
                        end else begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                end
            end
            StVend: begin
                coin_reject_d = coin;
                if (disp_ack_i) begin
                    dispense_d = 1'b0;
                    if (stock_q[disp_id_q] != '0) begin
                        stock_d[disp_id_q] = stock_q[disp_id_q] - STOCK_W'(1);
                    end
                    if (credit_q != '0) begin
                        state_d     = StChange;
                        chg_valid_d = 1'b1;
                        chg_amt_d   = credit_q;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StChange: begin
                coin_reject_d = coin;
                if (chg_ready_i && chg_valid_q) begin
                    chg_valid_d = 1'b0;
                    chg_amt_d   = '0;
                    credit_d    = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        for (int i = 0; i < NUM_PROD; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            timer_q       <= '0;
            dispense_q    <= 1'b0;
            disp_id_q     <= '0;
            chg_valid_q   <= 1'b0;
            chg_amt_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
            sold_out_q    <= '0;
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            timer_q       <= timer_d;
            dispense_q    <= dispense_d;
            disp_id_q     <= disp_id_d;
            chg_valid_q   <= chg_valid_d;
            chg_amt_q     <= chg_amt_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
            sold_out_q    <= sold_out_d;
            stock_q       <= stock_d;
        end
    end

    assign dispense_o    = dispense_q;
    assign disp_id_o     = disp_id_q;
    assign chg_valid_o   = chg_valid_q;
    assign chg_amt_o     = chg_amt_q;
    assign coin_reject_o = coin_reject_q;
    assign sel_err_o     = sel_err_q;
    assign sold_out_o    = sold_out_q;
    assign credit_o      = credit_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: linear steps, outputs sampled 1ns after each rising edge.
module tb_vend_ctrl_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cash;
    logic        sel_valid;
    logic [1:0]  sel_id;
    logic        cancel;
    logic [15:0] price_tbl;
    logic        restock;
    logic [1:0]  restock_id;
    logic        dispense;
    logic [1:0]  disp_id;
    logic        disp_ack;
    logic        chg_valid;
    logic [5:0]  chg_amt;
    logic        chg_ready;
    logic        coin_reject;
    logic        sel_err;
    logic [3:0]  sold_out;
    logic [5:0]  credit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vend_ctrl_multi dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cash_i        (cash),
        .sel_valid_i   (sel_valid),
        .sel_id_i      (sel_id),
        .cancel_i      (cancel),
        .price_tbl_i   (price_tbl),
        .restock_i     (restock),
        .restock_id_i  (restock_id),
        .dispense_o    (dispense),
        .disp_id_o     (disp_id),
        .disp_ack_i    (disp_ack),
        .chg_valid_o   (chg_valid),
        .chg_amt_o     (chg_amt),
        .chg_ready_i   (chg_ready),
        .coin_reject_o (coin_reject),
        .sel_err_o     (sel_err),
        .sold_out_o    (sold_out),
        .credit_o      (credit)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b1; cash = 2'b00; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0;
        price_tbl = {4'd2, 4'd5, 4'd4, 4'd3};
        restock = 1'b0; restock_id = 2'd0; disp_ack = 1'b0; chg_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_dispense", 32'(dispense), 0);
        chk("rst_chg_valid", 32'(chg_valid), 0);
        chk("rst_credit", 32'(credit), 0);
        chk("rst_sold_out", 32'(sold_out), 0);
        chk("rst_flags", 32'({coin_reject, sel_err}), 0);

        // 1 + 2 = 3, buy product 0 (price 3)
        cash = 2'b01; tick(); cash = 2'b00;
        chk("t1_credit1", 32'(credit), 1);
        cash = 2'b10; tick(); cash = 2'b00;
        chk("t1_credit3", 32'(credit), 3);
        sel_valid = 1'b1; sel_id = 2'd0; tick(); sel_valid = 1'b0;
        chk("t1_dispense", 32'(dispense), 1);
        chk("t1_disp_id", 32'(disp_id), 0);
        chk("t1_credit0", 32'(credit), 0);
        chk("t1_no_chg", 32'(chg_valid), 0);
        tick();
        chk("t1_dispense_held", 32'(dispense), 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t1_dispense_done", 32'(dispense), 0);
        chk("t1_no_chg_after", 32'(chg_valid), 0);

        // 5, buy product 1 (price 4), change 1; coin in CHANGE rejected
        cash = 2'b11; tick(); cash = 2'b00;
        chk("t2_credit5", 32'(credit), 5);
        sel_valid = 1'b1; sel_id = 2'd1; tick(); sel_valid = 1'b0;
        chk("t2_dispense", 32'(dispense), 1);
        chk("t2_disp_id", 32'(disp_id), 1);
        chk("t2_credit1", 32'(credit), 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t2_chg_valid", 32'(chg_valid), 1);
        chk("t2_chg_amt", 32'(chg_amt), 1);
        cash = 2'b01; tick(); cash = 2'b00;
        chk("t2_chg_hold", 32'(chg_valid), 1);
        chk("t2_coin_rej_change", 32'(coin_reject), 1);
        chk("t2_credit_kept", 32'(credit), 1);
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;
        chk("t2_chg_done", 32'(chg_valid), 0);
        chk("t2_credit_clr", 32'(credit), 0);
        chk("t2_rej_pulse_end", 32'(coin_reject), 0);

        // Credit limit: 5+2+2 = 9, +2 rejected, +1 -> 10
        cash = 2'b11; tick(); cash = 2'b10; tick(); cash = 2'b10; tick(); cash = 2'b00;
        chk("t3_credit9", 32'(credit), 9);
        cash = 2'b10; tick(); cash = 2'b00;
        chk("t3_reject", 32'(coin_reject), 1);
        chk("t3_credit_still9", 32'(credit), 9);
        cash = 2'b01; tick(); cash = 2'b00;
        chk("t3_credit10", 32'(credit), 10);
        chk("t3_accept_no_rej", 32'(coin_reject), 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t3_cancel_chg", 32'(chg_valid), 1);
        chk("t3_cancel_amt", 32'(chg_amt), 10);
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;
        chk("t3_idle", 32'(credit), 0);

        // Insufficient credit then idle timeout refund
        cash = 2'b10; tick(); cash = 2'b00;
        sel_valid = 1'b1; sel_id = 2'd2; tick(); sel_valid = 1'b0;
        chk("t4_sel_err", 32'(sel_err), 1);
        chk("t4_credit2", 32'(credit), 2);
        chk("t4_no_dispense", 32'(dispense), 0);
        tick();
        chk("t4_sel_err_pulse", 32'(sel_err), 0);
        n = 0;
        while (!chg_valid && n < 1100) begin
            tick();
            n++;
        end
        chk("t4_timeout_fired", 32'(chg_valid), 1);
        chk("t4_timeout_window", 32'(n >= 995 && n <= 1005), 1);
        chk("t4_timeout_amt", 32'(chg_amt), 2);
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;
        chk("t4_idle", 32'(chg_valid), 0);

        // Sell out product 3 (price 2), then restock
        for (int i = 0; i < 8; i++) begin
            cash = 2'b10; tick(); cash = 2'b00;
            sel_valid = 1'b1; sel_id = 2'd3; tick(); sel_valid = 1'b0;
            disp_ack = 1'b1; tick(); disp_ack = 1'b0;
            if (i == 6) chk("t5_not_sold_out", 32'(sold_out), 0);
        end
        chk("t5_sold_out", 32'(sold_out), 4'b1000);
        cash = 2'b10; tick(); cash = 2'b00;
        sel_valid = 1'b1; sel_id = 2'd3; tick(); sel_valid = 1'b0;
        chk("t5_sel_err", 32'(sel_err), 1);
        chk("t5_no_dispense", 32'(dispense), 0);
        restock = 1'b1; restock_id = 2'd3; tick(); restock = 1'b0;
        chk("t5_restock_ignored", 32'(sold_out), 4'b1000);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;
        restock = 1'b1; restock_id = 2'd3; tick(); restock = 1'b0;
        chk("t5_restocked", 32'(sold_out), 0);

        // Simultaneous cancel + sel + coin at credit 3
        cash = 2'b10; tick(); cash = 2'b01; tick(); cash = 2'b00;
        chk("t6_credit3", 32'(credit), 3);
        cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; cash = 2'b01; tick();
        cancel = 1'b0; sel_valid = 1'b0; cash = 2'b00;
        chk("t6_coin_reject", 32'(coin_reject), 1);
        chk("t6_chg_valid", 32'(chg_valid), 1);
        chk("t6_chg_amt", 32'(chg_amt), 3);
        chk("t6_no_dispense", 32'(dispense), 0);
        chg_ready = 1'b1; tick(); chg_ready = 1'b0;

        // Reset during VEND clears everything
        cash = 2'b11; tick(); cash = 2'b00;
        sel_valid = 1'b1; sel_id = 2'd1; tick(); sel_valid = 1'b0;
        chk("t6_vend_pre_rst", 32'({dispense, disp_id}), 3'b101);
        rst = 1'b1; cash = 2'b01; tick(); rst = 1'b0; cash = 2'b00;
        chk("t6_rst_dispense", 32'(dispense), 0);
        chk("t6_rst_disp_id", 32'(disp_id), 0);
        chk("t6_rst_credit", 32'(credit), 0);
        chk("t6_rst_chg", 32'({chg_valid, chg_amt}), 0);
        chk("t6_rst_flags", 32'({coin_reject, sel_err, sold_out}), 0);

        // Price 0 vends straight from IDLE
        price_tbl = {4'd2, 4'd5, 4'd4, 4'd0};
        sel_valid = 1'b1; sel_id = 2'd0; tick(); sel_valid = 1'b0;
        chk("t7_free_dispense", 32'(dispense), 1);
        chk("t7_free_err", 32'(sel_err), 0);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t7_free_done", 32'({dispense, chg_valid}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
